// File: rtl/sass_pkg.sv
// rtl/sass_pkg.sv - shared constants and voice state record for the SaSS voice allocator
package sass_pkg;
  localparam int NUM_KEYS   = 15;
  localparam int NUM_VOICES = 4;
  localparam int KEY_W      = $clog2(NUM_KEYS);
  localparam int RANK_W     = $clog2(NUM_VOICES);
  localparam logic [RANK_W-1:0] RANK_OLDEST = RANK_W'(NUM_VOICES - 1);

  typedef struct packed {
    logic              valid;
    logic [KEY_W-1:0]  key;
    logic [RANK_W-1:0] rank;
  } voice_t;
endpackage

// File: rtl/sass_voice_alloc_if.sv
// rtl/sass_voice_alloc_if.sv - key bank in, voice control out
interface sass_voice_alloc_if;
  import sass_pkg::*;

  logic                        enable;
  logic [NUM_KEYS-1:0]         keys;
  logic [NUM_VOICES-1:0]       voice_valid;
  logic [NUM_VOICES*KEY_W-1:0] voice_key;
  logic [NUM_VOICES-1:0]       voice_trig;
  logic                        steal;

  modport master (
    output enable, keys,
    input  voice_valid, voice_key, voice_trig, steal
  );

  modport slave (
    input  enable, keys,
    output voice_valid, voice_key, voice_trig, steal
  );
endinterface

// File: rtl/sass_prienc.sv
// rtl/sass_prienc.sv - lowest-set-bit priority encoder
module sass_prienc #(
  parameter int W  = 4,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req,
  output logic          found,
  output logic [IW-1:0] idx
);
  always_comb begin
    found = |req;
    idx   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end
endmodule

// File: rtl/sass_voice_alloc.sv
// rtl/sass_voice_alloc.sv - polyphonic voice allocator with oldest-voice stealing
module sass_voice_alloc
  import sass_pkg::*;
(
  input  logic              hwclk,
  input  logic              reset,
  sass_voice_alloc_if.slave bus
);
  logic [NUM_KEYS-1:0]   keys_q, pending, rise, fall, granted, pending_next;
  logic [NUM_VOICES-1:0] live, trig_q;
  logic                  steal_q;
  voice_t                voices [NUM_VOICES];

  logic                  pend_found, free_found, alloc;
  logic [KEY_W-1:0]      gkey;
  logic [RANK_W-1:0]     free_idx, old_idx, vsel;

  assign rise = bus.keys & ~keys_q;
  assign fall = ~bus.keys & keys_q;

  // Releases are applied before the free search so a freed voice is reusable at once.
  always_comb begin
    live = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      live[v] = voices[v].valid & ~fall[voices[v].key];
    end
  end

  always_comb begin
    old_idx = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (voices[v].rank == RANK_OLDEST) old_idx = RANK_W'(v);
    end
  end

  sass_prienc #(.W(NUM_KEYS), .IW(KEY_W)) u_pend_enc (
    .req   (pending),
    .found (pend_found),
    .idx   (gkey)
  );

  sass_prienc #(.W(NUM_VOICES), .IW(RANK_W)) u_free_enc (
    .req   (~live),
    .found (free_found),
    .idx   (free_idx)
  );

  // A granted key that is released in the same cycle is consumed without sounding.
  assign granted      = pend_found ? (NUM_KEYS'(1) << gkey) : '0;
  assign pending_next = (pending | rise) & ~fall & ~granted;
  assign alloc        = pend_found & ~fall[gkey] & bus.enable;
  assign vsel         = free_found ? free_idx : old_idx;

  always_ff @(posedge hwclk) begin
    if (reset) begin
      keys_q  <= '0;
      pending <= '0;
      trig_q  <= '0;
      steal_q <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        voices[v] <= '{valid: 1'b0, key: '0, rank: RANK_W'(v)};
      end
    end else begin
      keys_q  <= bus.keys;
      trig_q  <= '0;
      steal_q <= 1'b0;
      if (!bus.enable) begin
        pending <= '0;
        for (int v = 0; v < NUM_VOICES; v++) voices[v].valid <= 1'b0;
      end else begin
        pending <= pending_next;
        for (int v = 0; v < NUM_VOICES; v++) begin
          voices[v].valid <= live[v];
          if (alloc) begin
            if (RANK_W'(v) == vsel) begin
              voices[v].valid <= 1'b1;
              voices[v].key   <= gkey;
              voices[v].rank  <= '0;
              trig_q[v]       <= 1'b1;
            end else if (voices[v].rank < voices[vsel].rank) begin
              voices[v].rank <= voices[v].rank + 1'b1;
            end
          end
        end
        if (alloc) steal_q <= live[vsel];
      end
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
    assign bus.voice_valid[v]                = voices[v].valid;
    assign bus.voice_key[v*KEY_W +: KEY_W]   = voices[v].key;
  end
  assign bus.voice_trig = trig_q;
  assign bus.steal      = steal_q;
endmodule

// File: tb/tb_sass_voice_alloc.sv
// tb/tb_sass_voice_alloc.sv - directed table plus randomized reference-model bench for sass_voice_alloc
module tb_sass_voice_alloc;
  logic hwclk = 1'b0;
  logic reset;
  always #5 hwclk = ~hwclk;

  sass_voice_alloc_if bus();
  sass_voice_alloc dut (.hwclk(hwclk), .reset(reset), .bus(bus));

  int nvec = 0;
  int nerr = 0;

  // Reference: voice ownership plus an age list, most recently allocated first.
  logic [14:0] m_keysq, m_pend;
  logic [3:0]  m_valid, m_trig;
  logic [3:0]  m_key [4];
  logic        m_steal;
  int          lru [$];

  task automatic model_step(input logic [14:0] k, input logic en, input logic rst);
    logic [14:0] rs, fl, np;
    int g, v;
    bit found;
    if (rst) begin
      m_keysq = '0; m_pend = '0; m_valid = '0; m_trig = '0; m_steal = 1'b0;
      for (int i = 0; i < 4; i++) m_key[i] = '0;
      lru = {0, 1, 2, 3};
      return;
    end
    rs = k & ~m_keysq;
    fl = ~k & m_keysq;
    m_trig = '0; m_steal = 1'b0;
    if (!en) begin
      m_valid = '0; m_pend = '0; m_keysq = k;
      return;
    end
    for (int i = 0; i < 4; i++) if (m_valid[i] && fl[m_key[i]]) m_valid[i] = 1'b0;
    found = 0; g = 0;
    for (int i = 14; i >= 0; i--) if (m_pend[i]) begin found = 1; g = i; end
    np = (m_pend | rs) & ~fl;
    if (found) begin
      np[g] = 1'b0;
      if (!fl[g]) begin
        v = -1;
        for (int i = 3; i >= 0; i--) if (!m_valid[i]) v = i;
        if (v < 0) v = lru[$];
        m_steal = m_valid[v];
        m_valid[v] = 1'b1;
        m_key[v] = g[3:0];
        m_trig[v] = 1'b1;
        for (int i = 0; i < lru.size(); i++) if (lru[i] == v) begin lru.delete(i); break; end
        lru.push_front(v);
      end
    end
    m_pend = np;
    m_keysq = k;
  endtask

  function automatic logic [7:0] model_rank();
    logic [7:0] r = '0;
    for (int i = 0; i < lru.size(); i++) r[lru[i]*2 +: 2] = 2'(i);
    return r;
  endfunction

  task automatic cyc(input logic [14:0] k, input logic en, input logic rst, input string tag);
    logic [7:0] ar, er;
    logic [15:0] ek;
    bus.keys = k; bus.enable = en; reset = rst;
    model_step(k, en, rst);
    @(posedge hwclk); #1;
    for (int i = 0; i < 4; i++) begin
      ar[i*2 +: 2] = dut.voices[i].rank;
      ek[i*4 +: 4] = m_key[i];
    end
    er = model_rank();
    nvec++;
    if (bus.voice_valid !== m_valid || bus.voice_key !== ek || bus.voice_trig !== m_trig ||
        bus.steal !== m_steal || ar !== er || dut.pending !== m_pend) begin
      nerr++;
      $display("FAIL model[%s] got valid=%b key=%h trig=%b steal=%b rank=%h pend=%h want valid=%b key=%h trig=%b steal=%b rank=%h pend=%h",
               tag, bus.voice_valid, bus.voice_key, bus.voice_trig, bus.steal, ar, dut.pending,
               m_valid, ek, m_trig, m_steal, er, m_pend);
    end
  endtask

  typedef struct {
    logic [14:0] keys;
    logic        en;
    logic [3:0]  valid;
    logic [15:0] vkey;
    logic [3:0]  trig;
    logic        stl;
  } vec_t;

  vec_t tbl [27];
  logic [14:0] rk;
  logic ren, rrst;

  initial begin
    tbl[0]  = '{15'h0000, 1'b1, 4'b0000, 16'h0000, 4'b0000, 1'b0};
    tbl[1]  = '{15'h0020, 1'b1, 4'b0000, 16'h0000, 4'b0000, 1'b0};
    tbl[2]  = '{15'h0020, 1'b1, 4'b0001, 16'h0005, 4'b0001, 1'b0};
    tbl[3]  = '{15'h0020, 1'b1, 4'b0001, 16'h0005, 4'b0000, 1'b0};
    tbl[4]  = '{15'h0000, 1'b1, 4'b0000, 16'h0005, 4'b0000, 1'b0};
    tbl[5]  = '{15'h0000, 1'b1, 4'b0000, 16'h0005, 4'b0000, 1'b0};
    tbl[6]  = '{15'h001E, 1'b1, 4'b0000, 16'h0005, 4'b0000, 1'b0};
    tbl[7]  = '{15'h001E, 1'b1, 4'b0001, 16'h0001, 4'b0001, 1'b0};
    tbl[8]  = '{15'h001E, 1'b1, 4'b0011, 16'h0021, 4'b0010, 1'b0};
    tbl[9]  = '{15'h001E, 1'b1, 4'b0111, 16'h0321, 4'b0100, 1'b0};
    tbl[10] = '{15'h001E, 1'b1, 4'b1111, 16'h4321, 4'b1000, 1'b0};
    tbl[11] = '{15'h021E, 1'b1, 4'b1111, 16'h4321, 4'b0000, 1'b0};
    tbl[12] = '{15'h021E, 1'b1, 4'b1111, 16'h4329, 4'b0001, 1'b1};
    tbl[13] = '{15'h021E, 1'b1, 4'b1111, 16'h4329, 4'b0000, 1'b0};
    tbl[14] = '{15'h021C, 1'b1, 4'b1111, 16'h4329, 4'b0000, 1'b0};
    tbl[15] = '{15'h029C, 1'b1, 4'b1111, 16'h4329, 4'b0000, 1'b0};
    tbl[16] = '{15'h0298, 1'b1, 4'b1111, 16'h4379, 4'b0010, 1'b0};
    tbl[17] = '{15'h0298, 1'b1, 4'b1111, 16'h4379, 4'b0000, 1'b0};
    tbl[18] = '{15'h02D8, 1'b1, 4'b1111, 16'h4379, 4'b0000, 1'b0};
    tbl[19] = '{15'h0298, 1'b1, 4'b1111, 16'h4379, 4'b0000, 1'b0};
    tbl[20] = '{15'h0298, 1'b1, 4'b1111, 16'h4379, 4'b0000, 1'b0};
    tbl[21] = '{15'h0288, 1'b1, 4'b0111, 16'h4379, 4'b0000, 1'b0};
    tbl[22] = '{15'h0288, 1'b0, 4'b0000, 16'h4379, 4'b0000, 1'b0};
    tbl[23] = '{15'h0288, 1'b0, 4'b0000, 16'h4379, 4'b0000, 1'b0};
    tbl[24] = '{15'h0288, 1'b1, 4'b0000, 16'h4379, 4'b0000, 1'b0};
    tbl[25] = '{15'h0288, 1'b1, 4'b0000, 16'h4379, 4'b0000, 1'b0};
    tbl[26] = '{15'h0288, 1'b1, 4'b0000, 16'h4379, 4'b0000, 1'b0};

    bus.keys = '0; bus.enable = 1'b1; reset = 1'b1;
    cyc(15'h0, 1'b1, 1'b1, "reset0");
    cyc(15'h0, 1'b1, 1'b1, "reset1");

    for (int i = 0; i < 27; i++) begin
      cyc(tbl[i].keys, tbl[i].en, 1'b0, $sformatf("row%0d", i));
      nvec++;
      if (bus.voice_valid !== tbl[i].valid || bus.voice_key !== tbl[i].vkey ||
          bus.voice_trig !== tbl[i].trig || bus.steal !== tbl[i].stl) begin
        nerr++;
        $display("FAIL table row%0d got valid=%b key=%h trig=%b steal=%b want valid=%b key=%h trig=%b steal=%b",
                 i, bus.voice_valid, bus.voice_key, bus.voice_trig, bus.steal,
                 tbl[i].valid, tbl[i].vkey, tbl[i].trig, tbl[i].stl);
      end
    end

    // Reset mid-activity overrides enable and a fresh key press.
    cyc(15'h0001, 1'b1, 1'b0, "pre_rst");
    cyc(15'h0003, 1'b1, 1'b1, "mid_rst");
    nvec++;
    if (bus.voice_valid !== 4'b0 || bus.voice_trig !== 4'b0 || bus.steal !== 1'b0 || dut.pending !== 15'h0) begin
      nerr++;
      $display("FAIL mid_reset got valid=%b trig=%b steal=%b pend=%h want all zero",
               bus.voice_valid, bus.voice_trig, bus.steal, dut.pending);
    end

    rk = '0;
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < 15; b++) if ($urandom_range(0, 6) == 0) rk[b] = ~rk[b];
      ren  = ($urandom_range(0, 29) != 0);
      rrst = ($urandom_range(0, 249) == 0);
      cyc(rk, ren, rrst, $sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
